// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types, constants and helpers for the GEMM tile scheduler
package gemm_pkg;

   localparam int GemmSizeWidth = 32;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      DRAIN,
      WRITE,
      DONE
   } sched_state_e;

   // ceil(x / 2**lg) by add-and-shift; one extra bit keeps the bias add from wrapping.
   function automatic logic [GemmSizeWidth-1:0] ceil_div_pow2(input logic [GemmSizeWidth-1:0] x,
                                                              input int unsigned lg);
      logic [GemmSizeWidth:0] bias;
      logic [GemmSizeWidth:0] sum;
      bias = ((GemmSizeWidth+1)'(1) << lg) - (GemmSizeWidth+1)'(1);
      sum  = {1'b0, x} + bias;
      sum  = sum >> lg;
      return sum[GemmSizeWidth-1:0];
   endfunction

endpackage

// File: rtl/gemm_loop_counter.sv
// rtl/gemm_loop_counter.sv - wrapping loop index with latched terminal value and last flag
module gemm_loop_counter #(
   parameter int Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             clear_i,
   input  logic             inc_i,
   input  logic [Width-1:0] max_i,
   output logic [Width-1:0] count_o,
   output logic             last_o
);

   logic [Width-1:0] count_q, count_d;
   logic [Width-1:0] max_q, max_d;

   // Load captures the terminal value and restarts at 0; increment wraps to 0 after the terminal value.
   always_comb begin
      count_d = count_q;
      max_d   = max_q;
      if (load_i) begin
         max_d   = max_i;
         count_d = '0;
      end else if (clear_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = (count_q == max_q) ? '0 : count_q + Width'(1);
      end
   end

   // Index and terminal-value registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         max_q   <= '0;
      end else begin
         count_q <= count_d;
         max_q   <= max_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == max_q);

endmodule

// File: rtl/gemm_tile_scheduler.sv
// rtl/gemm_tile_scheduler.sv - output-tile walker driving A/B reads, MAC control and C writes (option: GEMM_SCHED_PERF_EN)
module gemm_tile_scheduler
   import gemm_pkg::*;
#(
   parameter int AddrWidth     = 12,
   parameter int SizeAddrWidth = GemmSizeWidth,
   parameter int RowPar        = 4,
   parameter int ColPar        = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [SizeAddrWidth-1:0] M_size_i,
   input  logic [SizeAddrWidth-1:0] K_size_i,
   input  logic [SizeAddrWidth-1:0] N_size_i,
   output logic [AddrWidth-1:0]     sram_a_addr_o,
   output logic [AddrWidth-1:0]     sram_b_addr_o,
   output logic [AddrWidth-1:0]     sram_c_addr_o,
   output logic                     sram_c_we_o,
   output logic                     mac_valid_o,
   output logic                     mac_clr_o,
   output logic                     busy_o,
   output logic                     done_o
`ifdef GEMM_SCHED_PERF_EN
   ,
   output logic [31:0]              cycle_cnt_o,
   output logic [31:0]              tile_cnt_o
`endif
);

   localparam int RowLg = $clog2(RowPar);
   localparam int ColLg = $clog2(ColPar);
   localparam logic [SizeAddrWidth-1:0] One = SizeAddrWidth'(1);

   sched_state_e state_q, state_d;
   logic [SizeAddrWidth-1:0] k_size_q, k_size_d;
   logic [SizeAddrWidth-1:0] nt_q, nt_d;
   logic [SizeAddrWidth-1:0] a_base_q, a_base_d;
   logic [SizeAddrWidth-1:0] b_base_q, b_base_d;
   logic [SizeAddrWidth-1:0] c_row_q, c_row_d;
   logic [AddrWidth-1:0]     a_hold_q, b_hold_q;
   logic                     mac_valid_q, mac_clr_q;

   logic [SizeAddrWidth-1:0] mt, nt;
   logic [SizeAddrWidth-1:0] k_cnt, cb_cnt, rb_cnt_unused;
   logic                     k_last, cb_last, rb_last;
   logic                     start_acc, size_zero, calc;
   logic [AddrWidth-1:0]     a_addr_calc, b_addr_calc;

   assign mt        = SizeAddrWidth'(ceil_div_pow2(GemmSizeWidth'(M_size_i), RowLg));
   assign nt        = SizeAddrWidth'(ceil_div_pow2(GemmSizeWidth'(N_size_i), ColLg));
   assign size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
   assign calc      = (state_q == CALC);

   gemm_loop_counter #(.Width(SizeAddrWidth)) u_k_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(start_acc), .clear_i(1'b0), .inc_i(calc),
      .max_i(K_size_i - One), .count_o(k_cnt), .last_o(k_last)
   );

   gemm_loop_counter #(.Width(SizeAddrWidth)) u_cb_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(start_acc), .clear_i(1'b0),
      .inc_i(state_q == WRITE), .max_i(nt - One), .count_o(cb_cnt), .last_o(cb_last)
   );

   gemm_loop_counter #(.Width(SizeAddrWidth)) u_rb_cnt (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(start_acc), .clear_i(1'b0),
      .inc_i((state_q == WRITE) && cb_last), .max_i(mt - One), .count_o(rb_cnt_unused),
      .last_o(rb_last)
   );

   // Tile walk: bases advance by K per tile column / row so no multiplier is needed.
   always_comb begin
      state_d   = state_q;
      k_size_d  = k_size_q;
      nt_d      = nt_q;
      a_base_d  = a_base_q;
      b_base_d  = b_base_q;
      c_row_d   = c_row_q;
      start_acc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               start_acc = 1'b1;
               k_size_d  = K_size_i;
               nt_d      = nt;
               a_base_d  = '0;
               b_base_d  = '0;
               c_row_d   = '0;
               state_d   = size_zero ? DONE : CALC;
            end
         end
         CALC:  if (k_last) state_d = DRAIN;
         DRAIN: state_d = WRITE;
         WRITE: begin
            if (cb_last) begin
               b_base_d = '0;
               a_base_d = a_base_q + k_size_q;
               c_row_d  = c_row_q + nt_q;
               state_d  = rb_last ? DONE : CALC;
            end else begin
               b_base_d = b_base_q + k_size_q;
               state_d  = CALC;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, latched sizes, bases, held read addresses and the one-cycle-delayed MAC strobes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         k_size_q    <= '0;
         nt_q        <= '0;
         a_base_q    <= '0;
         b_base_q    <= '0;
         c_row_q     <= '0;
         a_hold_q    <= '0;
         b_hold_q    <= '0;
         mac_valid_q <= 1'b0;
         mac_clr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_size_q    <= k_size_d;
         nt_q        <= nt_d;
         a_base_q    <= a_base_d;
         b_base_q    <= b_base_d;
         c_row_q     <= c_row_d;
         mac_valid_q <= calc;
         mac_clr_q   <= calc && (k_cnt == '0);
         if (calc) begin
            a_hold_q <= a_addr_calc;
            b_hold_q <= b_addr_calc;
         end
      end
   end

   assign a_addr_calc   = AddrWidth'(a_base_q + k_cnt);
   assign b_addr_calc   = AddrWidth'(b_base_q + k_cnt);
   assign sram_a_addr_o = calc ? a_addr_calc : a_hold_q;
   assign sram_b_addr_o = calc ? b_addr_calc : b_hold_q;
   assign sram_c_we_o   = (state_q == WRITE);
   assign sram_c_addr_o = (state_q == WRITE) ? AddrWidth'(c_row_q + cb_cnt) : '0;
   assign mac_valid_o   = mac_valid_q;
   assign mac_clr_o     = mac_clr_q;
   assign busy_o        = (state_q == CALC) || (state_q == DRAIN) || (state_q == WRITE);
   assign done_o        = (state_q == DONE);

`ifdef GEMM_SCHED_PERF_EN
   logic [31:0] cycle_cnt_q, tile_cnt_q;

   // Profiling counters: restart on each accepted start, saturate, hold after completion.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_acc) begin
         cycle_cnt_q <= '0;
         tile_cnt_q  <= '0;
      end else begin
         if (busy_o && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if ((state_q == WRITE) && (tile_cnt_q != '1)) tile_cnt_q <= tile_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt_o = cycle_cnt_q;
   assign tile_cnt_o  = tile_cnt_q;
`endif

endmodule
